instr_mem_sync: RTL

//  Parametrised, clocked instruction memory for the MIPS fetch stage, replacing the fixed combinational ROM.

---
 rtl/instr_mem_sync.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory for the fetch stage: registered read port, run-time load
// port, and a post-reset sequencer that zeroes every word before fetches are served.
module instr_mem_sync #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int CLEAR_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic              ready
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = ADDR_W - 2;
  // One spare bit so the range compare never degenerates when DEPTH fills the address space
  localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam state_t S_INIT = (CLEAR_EN != 0) ? S_CLEAR : S_READY;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_clr_cnt;
  logic               w_cnt_inc;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_we;
  logic [CNT_W-1:0]   w_waddr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_fetch;
  logic               w_ld_bad;

  logic [IDX_W-1:0]   w_f_idx;
  logic [IDX_W-1:0]   w_l_idx;
  logic               w_f_ok;
  logic               w_l_ok;

  logic [DATA_W-1:0]  r_data_p1;
  logic               r_vld_p1;
  logic               r_fault_p1;
  logic               r_ld_err_p1;

  assign w_f_idx = fetch_addr[ADDR_W-1:2];
  assign w_l_idx = ld_addr[ADDR_W-1:2];
  assign w_f_ok  = (fetch_addr[1:0] == 2'b00) && ({1'b0, w_f_idx} < DEPTH_X);
  assign w_l_ok  = (ld_addr[1:0] == 2'b00) && ({1'b0, w_l_idx} < DEPTH_X);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    w_fetch     = 1'b0;
    w_ld_bad    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_CLEAR: begin
          w_we    = 1'b1;
          w_waddr = r_clr_cnt;
          if (r_clr_cnt == CNT_LAST) w_state_nxt = S_READY;
          else                       w_cnt_inc   = 1'b1;
        end
        S_READY: begin
          w_fetch = fetch_req;
          if (ld_en) begin
            if (w_l_ok) begin
              w_we    = 1'b1;
              w_waddr = w_l_idx[CNT_W-1:0];
              w_wdata = ld_data;
            end else begin
              w_ld_bad = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  // Single write port shared by the clear sequencer and the load port
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // p1: registered fetch result; the read samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_fault_p1  <= 1'b0;
      r_data_p1   <= '0;
      r_ld_err_p1 <= 1'b0;
      r_clr_cnt   <= '0;
    end else begin
      r_vld_p1    <= w_fetch;
      r_ld_err_p1 <= w_ld_bad;
      if (w_cnt_inc) r_clr_cnt <= r_clr_cnt + CNT_W'(1);
      if (w_fetch) begin
        r_fault_p1 <= !w_f_ok;
        r_data_p1  <= w_f_ok ? r_mem[w_f_idx[CNT_W-1:0]] : '0;
      end
    end
  end

  assign rd_data  = r_data_p1;
  assign rd_valid = r_vld_p1;
  assign rd_fault = r_fault_p1;
  assign ld_err   = r_ld_err_p1;
  assign ready    = (r_state == S_READY) && !reset;

endmodule
